// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
//  song_sequencer : walks a note-duration ROM and gates a tone with an
//  articulation gap; strobes each note start and flags end of song.
//  Revision 1.0
// ============================================================================
module song_sequencer #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int GAP_CYCLES = CLOCK_FREQ / 100,
  parameter int INDEX_W    = 11,
  parameter int DUR_W      = 29,
  parameter bit LOOP       = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               play,
  input  logic               restart,
  input  logic [DUR_W-1:0]   note_dur,
  output logic [INDEX_W-1:0] note_index,
  output logic               note_on,
  output logic               note_strobe,
  output logic               song_done
);

  localparam logic [DUR_W-1:0]   GAP_LEN = DUR_W'(GAP_CYCLES);
  localparam logic [DUR_W:0]     GAP_X2  = (DUR_W+1)'(2 * GAP_CYCLES);
  localparam logic [INDEX_W-1:0] IDX_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ON   = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic               has_gap_q, has_gap_d;
  logic               note_on_q, note_on_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;
  logic               advance;

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    has_gap_d = has_gap_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    advance   = 1'b0;

    case (state_q)
      S_IDLE: if (play) state_d = S_LOAD;
      S_LOAD: begin
        if (note_dur == '0) begin
          // an empty song (terminator at index 0) parks in DONE even when looping
          if (!LOOP || index_q == '0) begin
            state_d = S_DONE;
          end else begin
            index_d = '0;
            done_d  = 1'b1;
          end
        end else begin
          if (GAP_CYCLES > 0 && {1'b0, note_dur} > GAP_X2) begin
            cnt_d     = note_dur - GAP_LEN - DUR_W'(1);
            has_gap_d = 1'b1;
          end else begin
            cnt_d     = note_dur - DUR_W'(1);
            has_gap_d = 1'b0;
          end
          state_d  = S_ON;
          strobe_d = 1'b1;
        end
      end
      S_ON: begin
        if (play) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DUR_W'(1);
          end else if (has_gap_q) begin
            cnt_d   = GAP_LEN - DUR_W'(1);
            state_d = S_GAP;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (play) begin
          if (cnt_q != '0) cnt_d = cnt_q - DUR_W'(1);
          else             advance = 1'b1;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (index_q == IDX_MAX) begin
        state_d = S_DONE;
      end else begin
        index_d = index_q + INDEX_W'(1);
        state_d = S_LOAD;
      end
    end

    if (state_d == S_DONE && !LOOP) done_d = 1'b1;
    note_on_d = (state_d == S_ON) && play;

    if (restart) begin
      state_d   = S_IDLE;
      index_d   = '0;
      cnt_d     = '0;
      has_gap_d = 1'b0;
      note_on_d = 1'b0;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      cnt_q     <= '0;
      has_gap_q <= 1'b0;
      note_on_q <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      cnt_q     <= cnt_d;
      has_gap_q <= has_gap_d;
      note_on_q <= note_on_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
    end
  end

  assign note_index  = index_q;
  assign note_on     = note_on_q;
  assign note_strobe = strobe_q;
  assign song_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// tb_song_sequencer : two sequencers (LOOP=0 / LOOP=1) on mock ROMs, checked
// cycle by cycle against a slot-position reference model.
module tb_song_sequencer;

  localparam int GAP   = 2;
  localparam int IDX_W = 3;
  localparam int DW    = 8;
  localparam int TOP   = (1 << IDX_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, play, restart;
  int   rom [2][8];

  logic [DW-1:0]    dur0, dur1;
  logic [IDX_W-1:0] idx0, idx1;
  logic             on0, on1, stb0, stb1, done0, done1;

  assign dur0 = DW'(rom[0][idx0]);
  assign dur1 = DW'(rom[1][idx1]);

  song_sequencer #(.CLOCK_FREQ(200), .GAP_CYCLES(GAP), .INDEX_W(IDX_W), .DUR_W(DW), .LOOP(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .play(play), .restart(restart), .note_dur(dur0),
    .note_index(idx0), .note_on(on0), .note_strobe(stb0), .song_done(done0));

  song_sequencer #(.CLOCK_FREQ(200), .GAP_CYCLES(GAP), .INDEX_W(IDX_W), .DUR_W(DW), .LOOP(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .play(play), .restart(restart), .note_dur(dur1),
    .note_index(idx1), .note_on(on1), .note_strobe(stb1), .song_done(done1));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s : got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a song is a list of slots; pos counts active cycles into the
  // current slot (0 = the load cycle, 1..on_len sounding, the rest silent).
  localparam int M_IDLE = 0, M_PLAY = 1, M_DONE = 2;
  int m_mode [2];
  int m_idx  [2];
  int m_pos  [2];
  bit e_on   [2];
  bit e_stb  [2];
  bit e_done [2];
  bit started = 1'b0;

  function automatic int on_len_of(input int dur);
    return (dur > 2 * GAP) ? dur - GAP : dur;
  endfunction

  task automatic model_step(input int d);
    bit looping;
    int dur;
    looping  = (d == 1);
    e_stb[d] = 1'b0;
    e_done[d] = 1'b0;
    e_on[d]  = 1'b0;
    if (rst || restart) begin
      m_mode[d] = M_IDLE; m_idx[d] = 0; m_pos[d] = 0;
      return;
    end
    case (m_mode[d])
      M_IDLE: if (play) begin m_mode[d] = M_PLAY; m_pos[d] = 0; end
      M_PLAY: begin
        dur = rom[d][m_idx[d]];
        if (m_pos[d] == 0) begin
          if (dur == 0) begin
            if (!looping || m_idx[d] == 0) m_mode[d] = M_DONE;
            else begin m_idx[d] = 0; e_done[d] = 1'b1; end
          end else begin
            m_pos[d] = 1; e_stb[d] = 1'b1;
          end
        end else if (play) begin
          if (m_pos[d] == dur) begin
            if (m_idx[d] == TOP) m_mode[d] = M_DONE;
            else begin m_idx[d]++; m_pos[d] = 0; end
          end else begin
            m_pos[d]++;
          end
        end
      end
      default: ;
    endcase
    if (m_mode[d] == M_DONE && !looping) e_done[d] = 1'b1;
    dur = rom[d][m_idx[d]];
    if (m_mode[d] == M_PLAY && m_pos[d] >= 1 && m_pos[d] <= on_len_of(dur)) e_on[d] = play;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("idx0", int'(idx0), m_idx[0]);  chk("on0", int'(on0), int'(e_on[0]));
      chk("stb0", int'(stb0), int'(e_stb[0])); chk("done0", int'(done0), int'(e_done[0]));
      chk("idx1", int'(idx1), m_idx[1]);  chk("on1", int'(on1), int'(e_on[1]));
      chk("stb1", int'(stb1), int'(e_stb[1])); chk("done1", int'(done1), int'(e_done[1]));
    end
  end

  task automatic set_rom(input int d, input int a, input int b, input int c, input int e);
    for (int i = 0; i < 8; i++) rom[d][i] = 0;
    rom[d][0] = a; rom[d][1] = b; rom[d][2] = c; rom[d][3] = e;
  endtask

  task automatic do_reset();
    rst = 1'b1; restart = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int scyc[$];
    int k;
    int cnt;
    rst = 1'b1; play = 1'b0; restart = 1'b0;
    set_rom(0, 5, 3, 1, 0);
    set_rom(1, 5, 3, 1, 0);
    do_reset();
    chk("rst_idx0", int'(idx0), 0); chk("rst_on0", int'(on0), 0);
    chk("rst_done0", int'(done0), 0); chk("rst_stb0", int'(stb0), 0);

    // full song, play held, with strobe spacing
    play = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (stb0) scyc.push_back(i);
    end
    chk("strobe_count", scyc.size(), 3);
    if (scyc.size() >= 3) begin
      chk("slot_gap01", scyc[1] - scyc[0], 6);
      chk("slot_gap12", scyc[2] - scyc[1], 4);
    end
    chk("end_idx", int'(idx0), 3);
    chk("end_done", int'(done0), 1);
    chk("end_on", int'(on0), 0);

    // pause during the second ON cycle of idx0
    do_reset();
    play = 1'b1;
    for (k = 0; k < 20 && !stb0; k++) @(negedge clk);
    chk("wait_strobe_pause", int'(stb0), 1);
    @(negedge clk);
    play = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("paused_on", int'(on0), 0);
    end
    play = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (stb0 && idx0 == 0) cnt++;
    end
    chk("no_restrobe", cnt, 0);

    // restart pulse during ON of idx1
    do_reset();
    play = 1'b1;
    for (k = 0; k < 30 && !(idx0 == 1 && on0); k++) @(negedge clk);
    chk("wait_idx1_on", int'(idx0 == 1 && on0), 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_idx", int'(idx0), 0);
    chk("restart_on", int'(on0), 0);
    repeat (25) @(negedge clk);
    chk("replay_idx", int'(idx0), 3);

    // rst in the middle of the first gap
    do_reset();
    play = 1'b1;
    for (k = 0; k < 20 && !stb0; k++) @(negedge clk);
    for (k = 0; k < 20 && on0; k++) @(negedge clk);
    chk("wait_gap", int'(!on0 && idx0 == 0), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midgap_idx", int'(idx0), 0); chk("midgap_on", int'(on0), 0);
    chk("midgap_done", int'(done0), 0);
    rst = 1'b0;

    // empty song with LOOP=1 must park
    rst = 1'b1;
    set_rom(1, 0, 0, 0, 0);
    do_reset();
    play = 1'b1;
    repeat (20) @(negedge clk);
    chk("empty_loop_idx", int'(idx1), 0);
    chk("empty_loop_on", int'(on1), 0);

    // randomized ROMs and control
    for (int s = 0; s < 8; s++) begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 8; i++)
          rom[d][i] = (s % 3 == 2) ? int'($urandom_range(1, 12)) :
                      (($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12)));
      do_reset();
      for (int c = 0; c < 160; c++) begin
        @(negedge clk);
        play    = ($urandom_range(0, 9) < 8);
        restart = ($urandom_range(0, 49) == 0);
        rst     = ($urandom_range(0, 149) == 0);
      end
      restart = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
